// File: rtl/div_unit_pkg.sv
// Shared types and sizing for the iterative RV32M divider.
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage request/write-back bundle between the core and the divider.
interface div_unit_if;
  import div_unit_pkg::*;

  logic             start_i;
  logic             kill_i;
  div_op_e          op_i;
  logic [XLEN-1:0]  rs1_data_i;
  logic [XLEN-1:0]  rs2_data_i;
  logic [4:0]       rd_addr_i;
  logic             busy_o;
  logic             valid_o;
  logic             rd_wren_o;
  logic [4:0]       rd_addr_o;
  logic [XLEN-1:0]  rd_data_o;
  div_state_e       state_o;

  // start_i is accepted only on an edge where busy_o is low; valid_o is a
  // one-cycle strobe with no back-pressure, so the core must take it then.
  modport master (
    output start_i, kill_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i,
    input  busy_o, valid_o, rd_wren_o, rd_addr_o, rd_data_o, state_o
  );

  modport slave (
    input  start_i, kill_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i,
    output busy_o, valid_o, rd_wren_o, rd_addr_o, rd_data_o, state_o
  );

endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division step on magnitudes.
module div_unit_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvsr,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  // i_rem < i_dvsr always holds, so the subtract borrow alone decides rem >= divisor.
  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_dvsr};
  assign w_ge    = ~w_diff[XLEN];
  assign o_rem   = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign o_quo   = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider: DIV/DIVU/REM/REMU, one quotient bit per cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  div_unit_if.slave  bus
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       r_state, w_state_n;
  logic             r_is_rem, r_neg_q, r_neg_r;
  logic [XLEN-1:0]  r_rem, r_quo, r_dvsr, r_rd_data;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_rd_addr;

  logic             w_signed, w_a_neg, w_b_neg, w_div_zero, w_ovf, w_last;
  logic [XLEN-1:0]  w_a_abs, w_b_abs, w_rem_n, w_quo_n, w_result;

  assign w_signed   = op_is_signed(bus.op_i);
  assign w_a_neg    = w_signed & bus.rs1_data_i[XLEN-1];
  assign w_b_neg    = w_signed & bus.rs2_data_i[XLEN-1];
  assign w_a_abs    = w_a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
  assign w_b_abs    = w_b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
  assign w_div_zero = (bus.rs2_data_i == '0);
  assign w_ovf      = w_signed && (bus.rs1_data_i == MIN_INT) && (bus.rs2_data_i == '1);
  assign w_last     = (r_cnt == CNT_W'(XLEN-1));

  div_unit_step u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_n),
    .o_quo  (w_quo_n)
  );

  assign w_result = r_is_rem ? (r_neg_r ? -w_rem_n : w_rem_n)
                             : (r_neg_q ? -w_quo_n : w_quo_n);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_state_n = (w_div_zero || w_ovf) ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_n = S_DONE;
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    if (bus.kill_i) w_state_n = S_IDLE;
  end

  // Special cases write their result on the launch edge, which is also their DONE-entry edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else if (!bus.kill_i) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_is_rem  <= op_is_rem(bus.op_i);
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_rem     <= '0;
            r_quo     <= w_a_abs;
            r_dvsr    <= w_b_abs;
            r_cnt     <= '0;
            r_rd_addr <= bus.rd_addr_i;
            if (w_div_zero)
              r_rd_data <= op_is_rem(bus.op_i) ? bus.rs1_data_i : '1;
            else if (w_ovf)
              r_rd_data <= op_is_rem(bus.op_i) ? '0 : MIN_INT;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_rd_data <= w_result;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o    = (r_state != S_IDLE);
  assign bus.valid_o   = (r_state == S_DONE);
  assign bus.rd_wren_o = (r_state == S_DONE) && (r_rd_addr != 5'd0);
  assign bus.rd_addr_o = r_rd_addr;
  assign bus.rd_data_o = r_rd_data;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed RV32M corner cases plus random ops.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_unit_if bus();

  div_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [XLEN-1:0] exp_q[$];
  logic [4:0]      exp_rd_q[$];
  int unsigned     exp_cyc_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension results from plain SV arithmetic.
  function automatic logic [XLEN-1:0] ref_div(div_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [XLEN-1:0] q, r;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (op == OP_DIVU || op == OP_REMU) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return (op == OP_REM || op == OP_REMU) ? r : q;
  endfunction

  function automatic bit is_special(div_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    return (b == 0) || ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic monitor();
    logic [XLEN-1:0] e;
    logic [4:0]      erd;
    int unsigned     ecyc;
    forever begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got valid_o=1 at cycle %0d, required 0 (nothing outstanding)", cyc);
        end else begin
          e    = exp_q.pop_front();
          erd  = exp_rd_q.pop_front();
          ecyc = exp_cyc_q.pop_front();
          check("rd_data", bus.rd_data_o, e);
          check("rd_addr", XLEN'(bus.rd_addr_o), XLEN'(erd));
          check("rd_wren", XLEN'(bus.rd_wren_o), XLEN'(erd != 5'd0));
          check("latency", XLEN'(cyc), XLEN'(ecyc));
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        n_cmp++;
        n_err++;
        $display("FAIL idle_timeout: got busy_o=%b after %0d cycles, required 0", bus.busy_o, n);
        break;
      end
    end
  endtask

  // Called at a negedge; the launch edge is the following posedge.
  task automatic launch(input div_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [4:0] rd);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_addr_i  = rd;
    @(negedge clk);
    bus.start_i    = 1'b0;
  endtask

  task automatic issue(input div_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [4:0] rd);
    wait_idle();
    exp_q.push_back(ref_div(op, a, b));
    exp_rd_q.push_back(rd);
    exp_cyc_q.push_back(cyc + 1 + (is_special(op, a, b) ? 0 : 32));
    launch(op, a, b, rd);
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_busy"},  XLEN'(bus.busy_o), '0);
    check({tag, "_valid"}, XLEN'(bus.valid_o), '0);
    check({tag, "_wren"},  XLEN'(bus.rd_wren_o), '0);
    check({tag, "_addr"},  XLEN'(bus.rd_addr_o), '0);
    check({tag, "_data"},  bus.rd_data_o, '0);
    check({tag, "_state"}, XLEN'(bus.state_o), XLEN'(S_IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    div_op_e         rop;
    logic [XLEN-1:0] ra, rb;
    int              sel;

    bus.start_i    = 1'b0;
    bus.kill_i     = 1'b0;
    bus.op_i       = OP_DIV;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;
    bus.rd_addr_i  = '0;

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_outputs_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_DIVU, 32'd100, 32'd7, 5'd3);
    issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd4);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5);
    issue(OP_DIV,  32'h1234_5678, 32'd0, 5'd6);
    issue(OP_REMU, 32'h1234_5678, 32'd0, 5'd7);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    issue(OP_DIVU, 32'd9, 32'd3, 5'd0);
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    issue(OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd11);

    // Kill mid-CALC with an ignored second start in between.
    wait_idle();
    launch(OP_DIVU, 32'd1000, 32'd3, 5'd12);
    repeat (3) @(negedge clk);
    launch(OP_DIV, 32'd55, 32'd5, 5'd13);
    check("busy_during_calc", XLEN'(bus.busy_o), XLEN'(1'b1));
    repeat (4) @(negedge clk);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    check("kill_busy",  XLEN'(bus.busy_o), '0);
    check("kill_valid", XLEN'(bus.valid_o), '0);
    check("kill_state", XLEN'(bus.state_o), XLEN'(S_IDLE));
    issue(OP_REMU, 32'd1000, 32'd3, 5'd14);

    // Kill and start on the same edge: kill wins.
    wait_idle();
    bus.kill_i = 1'b1;
    launch(OP_DIVU, 32'd50, 32'd5, 5'd15);
    bus.kill_i = 1'b0;
    check("kill_start_busy", XLEN'(bus.busy_o), '0);

    // Reset mid-CALC.
    wait_idle();
    launch(OP_REM, 32'hDEAD_BEEF, 32'd17, 5'd16);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_reset("midrst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      rop = div_op_e'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = $urandom_range(1, 15);
      else if (sel == 3) ra = $urandom_range(0, 100);
      else if (sel == 4) rb = -$urandom_range(1, 9);
      issue(rop, ra, rb, 5'($urandom_range(0, 31)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("outstanding", XLEN'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
